// File: rtl/key_pkg.sv
// Shared constants for the push-button input path: FSM encoding and board timing.
package key_pkg;

   localparam int unsigned CLK_HZ        = 50_000_000;
   localparam int unsigned DEBOUNCE_20MS = CLK_HZ / 50;
   localparam int unsigned LONG_1S       = CLK_HZ;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      PRESSED    = 2'd2,
      RELEASE_DB = 2'd3
   } key_fsm_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for an asynchronous single-bit board input.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low push-button into a clean level, one-cycle
// press/release/long-press pulses and a press-toggled output.
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
   parameter int unsigned LONG_CYCLES     = LONG_1S,
   parameter int unsigned CNT_W           =
      $clog2((DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic key_state,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic toggle
);

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic             w_key_s;
   key_fsm_e         r_state;
   key_fsm_e         w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_hold;
   logic [CNT_W-1:0] w_hold_nxt;
   logic             r_long_done;
   logic             w_long_done_nxt;
   logic             r_key_state;
   logic             w_key_state_nxt;
   logic             r_press;
   logic             w_press_nxt;
   logic             r_release;
   logic             w_release_nxt;
   logic             r_long;
   logic             w_long_nxt;
   logic             r_toggle;
   logic             w_toggle_nxt;

   // Idle pin level is high, so the synchroniser resets to 1.
   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (key_n),
      .o_q   (w_key_s)
   );

   // State register together with counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_hold      <= '0;
         r_long_done <= 1'b0;
         r_key_state <= 1'b0;
         r_press     <= 1'b0;
         r_release   <= 1'b0;
         r_long      <= 1'b0;
         r_toggle    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_hold      <= w_hold_nxt;
         r_long_done <= w_long_done_nxt;
         r_key_state <= w_key_state_nxt;
         r_press     <= w_press_nxt;
         r_release   <= w_release_nxt;
         r_long      <= w_long_nxt;
         r_toggle    <= w_toggle_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (!w_key_s) w_state_nxt = PRESS_DB;
         end
         PRESS_DB: begin
            if (w_key_s)                w_state_nxt = IDLE;
            else if (r_cnt == DB_LAST)  w_state_nxt = PRESSED;
         end
         PRESSED: begin
            if (w_key_s) w_state_nxt = RELEASE_DB;
         end
         RELEASE_DB: begin
            if (!w_key_s)               w_state_nxt = PRESSED;
            else if (r_cnt == DB_LAST)  w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Counter and output next values; hold_cnt only advances while in PRESSED.
   always_comb begin
      w_cnt_nxt       = '0;
      w_hold_nxt      = r_hold;
      w_long_done_nxt = r_long_done;
      w_key_state_nxt = r_key_state;
      w_press_nxt     = 1'b0;
      w_release_nxt   = 1'b0;
      w_long_nxt      = 1'b0;
      w_toggle_nxt    = r_toggle;
      case (r_state)
         PRESS_DB: begin
            if (!w_key_s) begin
               if (r_cnt == DB_LAST) begin
                  w_key_state_nxt = 1'b1;
                  w_press_nxt     = 1'b1;
                  w_toggle_nxt    = ~r_toggle;
                  w_hold_nxt      = '0;
                  w_long_done_nxt = 1'b0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
         end
         PRESSED: begin
            if (r_hold != LONG_LAST) begin
               w_hold_nxt = r_hold + CNT_ONE;
            end else if (!r_long_done) begin
               w_long_nxt      = 1'b1;
               w_long_done_nxt = 1'b1;
            end
         end
         RELEASE_DB: begin
            if (w_key_s) begin
               if (r_cnt == DB_LAST) begin
                  w_key_state_nxt = 1'b0;
                  w_release_nxt   = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
         end
         default: ;
      endcase
   end

   assign key_state   = r_key_state;
   assign key_press   = r_press;
   assign key_release = r_release;
   assign key_long    = r_long;
   assign toggle      = r_toggle;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a run-length reference model predicts events,
// a negedge monitor compares every cycle's pulses, level and toggle.
module tb_key_debounce;

   localparam int unsigned D = 8;
   localparam int unsigned L = 32;

   logic clk = 1'b0;
   logic rst;
   logic key_n;
   logic key_state, key_press, key_release, key_long, toggle;

   key_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_n       (key_n),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long),
      .toggle      (toggle)
   );

   always #5 clk = ~clk;

   typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_e;
   typedef struct {
      int       cyc;
      ev_kind_e kind;
   } ev_t;

   ev_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;
   int  cyc      = 0;

   // reference model state
   bit  hist[$];
   bit  m_pressed, m_tog, m_long_done, m_prev_ks;
   int  m_run, m_hold;

   // monitor bookkeeping
   int  n_press = 0, n_release = 0, n_long = 0;
   int  last_press = -1, last_release = -1, last_long = -1;
   logic [2:0] act_v, exp_v;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input ev_kind_e k);
      ev_t e;
      e.cyc  = cyc;
      e.kind = k;
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      hist.delete();
      hist.push_back(1'b1);
      hist.push_back(1'b1);
      m_pressed   = 1'b0;
      m_tog       = 1'b0;
      m_long_done = 1'b0;
      m_prev_ks   = 1'b1;
      m_run       = 0;
      m_hold      = 0;
      exp_q.delete();
   endtask

   // A level is accepted once D+1 consecutive synchronised samples agree;
   // hold time counts only cycles whose previous synchronised sample was still pressed.
   task automatic model_step();
      bit ks;
      hist.push_back(key_n);
      ks = hist.pop_front();
      if (!m_pressed) begin
         m_run = ks ? 0 : m_run + 1;
         if (m_run == int'(D) + 1) begin
            m_pressed   = 1'b1;
            m_tog       = ~m_tog;
            m_hold      = 0;
            m_long_done = 1'b0;
            m_run       = 0;
            push_ev(EV_PRESS);
         end
      end else begin
         if (!m_prev_ks && m_hold < int'(L)) begin
            m_hold++;
            if (m_hold == int'(L) && !m_long_done) begin
               m_long_done = 1'b1;
               push_ev(EV_LONG);
            end
         end
         m_run = ks ? m_run + 1 : 0;
         if (m_run == int'(D) + 1) begin
            m_pressed = 1'b0;
            m_run     = 0;
            push_ev(EV_RELEASE);
         end
      end
      m_prev_ks = ks;
   endtask

   always @(posedge clk) begin
      cyc++;
      if (rst) model_reset();
      else     model_step();
   end

   // Monitor: compare outputs against the model and the head of the event queue.
   always @(negedge clk) begin
      if (!rst) begin
         act_v = {key_press, key_release, key_long};
         exp_v = 3'b000;
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            case (exp_q[0].kind)
               EV_PRESS:   exp_v = 3'b100;
               EV_RELEASE: exp_v = 3'b010;
               default:    exp_v = 3'b001;
            endcase
            void'(exp_q.pop_front());
         end
         chk("pulses{press,release,long}", int'(act_v), int'(exp_v));
         chk("key_state", int'(key_state), int'(m_pressed));
         chk("toggle", int'(toggle), int'(m_tog));
         if (key_press)   begin n_press++;   last_press   = cyc; end
         if (key_release) begin n_release++; last_release = cyc; end
         if (key_long)    begin n_long++;    last_long    = cyc; end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_counts();
      n_press = 0; n_release = 0; n_long = 0;
      last_press = -1; last_release = -1; last_long = -1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_key_state"},   int'(key_state),   0);
      chk({tag, "_key_press"},   int'(key_press),   0);
      chk({tag, "_key_release"}, int'(key_release), 0);
      chk({tag, "_key_long"},    int'(key_long),    0);
      chk({tag, "_toggle"},      int'(toggle),      0);
   endtask

   initial begin
      int t0;
      rst   = 1'b1;
      key_n = 1'b1;
      tick(3);
      chk_all_zero("reset");
      rst = 1'b0;

      // idle: nothing happens
      clear_counts();
      tick(50);
      chk("idle_pulses", n_press + n_release + n_long, 0);

      // clean press and release
      t0 = cyc; key_n = 1'b0;
      tick(20);
      chk("press_latency", last_press - t0, 11);
      chk("press_count", n_press, 1);
      chk("press_level", int'(key_state), 1);
      chk("press_toggle", int'(toggle), 1);
      t0 = cyc; key_n = 1'b1;
      tick(20);
      chk("release_latency", last_release - t0, 11);
      chk("release_level", int'(key_state), 0);
      chk("short_press_no_long", n_long, 0);

      // bounce shorter than debounce window
      clear_counts();
      for (int i = 0; i < 40; i++) begin
         key_n = ((i / 3) % 2) != 0;
         tick(1);
      end
      key_n = 1'b1;
      tick(20);
      chk("bounce_pulses", n_press + n_release + n_long, 0);
      chk("bounce_toggle", int'(toggle), 1);

      // long press
      clear_counts();
      t0 = cyc; key_n = 1'b0;
      tick(100);
      chk("long_press_count", n_press, 1);
      chk("long_count", n_long, 1);
      chk("long_delay", last_long - last_press, 32);
      key_n = 1'b1;
      tick(20);
      chk("long_release_count", n_release, 1);

      // release bounce of 5 cycles extends hold time by 5
      clear_counts();
      key_n = 1'b0;
      tick(15);
      key_n = 1'b1;
      tick(5);
      key_n = 1'b0;
      tick(60);
      chk("rbounce_no_release", n_release, 0);
      chk("rbounce_long_count", n_long, 1);
      chk("rbounce_long_delay", last_long - last_press, 37);
      key_n = 1'b1;
      tick(20);

      // reset during PRESS_DB (cnt=5)
      clear_counts();
      key_n = 1'b0;
      tick(8);
      #2 rst = 1'b1;
      #1 chk_all_zero("rst_pressdb");
      tick(2);
      rst = 1'b0;
      t0  = cyc;
      tick(20);
      chk("rst_press_latency", last_press - t0, 11);
      chk("rst_press_toggle", int'(toggle), 1);

      // reset during PRESSED
      #2 rst = 1'b1;
      #1 chk_all_zero("rst_pressed");
      tick(2);
      key_n = 1'b1;
      rst   = 1'b0;
      clear_counts();
      tick(20);
      chk("post_rst_pulses", n_press + n_release + n_long, 0);

      // randomized level segments
      for (int s = 0; s < 60; s++) begin
         key_n = 1'($urandom_range(0, 1));
         tick(int'($urandom_range(1, 45)));
      end
      key_n = 1'b1;
      tick(40);
      chk("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
